// File: rtl/cic_decim_n.sv
// cic_decim_n: ORDER-stage CIC decimator for a 1-bit modulator bitstream.
// One start request runs ORDER*M input samples and returns one OUT_W-bit
// result with a valid pulse and a done level.
// Optional feature macro: CIC_CONT_MODE_EN. When it is defined, the i_cont
// and i_stop ports exist, and the block can deliver a result on every
// decimated sample until it is stopped.
module cic_decim_n #(
    parameter int ORDER = 2,
    parameter int M_W   = 10,
    parameter int OUT_W = ORDER*(M_W-1)+1
) (
    input  logic             i_clk,
    input  logic             i_rstb,
    input  logic             i_start,
    input  logic [M_W-1:0]   i_m_in,
    input  logic             i_d_in,
`ifdef CIC_CONT_MODE_EN
    input  logic             i_cont,
    input  logic             i_stop,
`endif
    output logic [OUT_W-1:0] o_d_out,
    output logic             o_valid,
    output logic             o_done,
    output logic             o_busy
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_OUT} state_t;

    // The tick counter saturates at ORDER. From that point on, every tick is a result tick.
    localparam logic [2:0] TICK_ORDER = 3'(ORDER);
    localparam logic [2:0] TICK_LAST  = 3'(ORDER-1);

    state_t           r_state;
    logic [M_W-1:0]   r_m;
    logic [M_W-1:0]   r_cnt;
    logic [2:0]       r_ticks;
    logic             r_cont;
    logic             r_pend;
    logic [OUT_W-1:0] r_comb_out;

    logic             w_cont_in;
    logic             w_stop;
    logic             w_accept;
    logic             w_run;
    logic             w_tick;
    logic [OUT_W-1:0] w_d_ext;

    logic [OUT_W-1:0] w_integ_q    [ORDER];
    logic [OUT_W-1:0] w_dly_q      [ORDER];
    logic [OUT_W-1:0] w_integ_next [ORDER];
    logic [OUT_W-1:0] w_comb       [ORDER+1];

`ifdef CIC_CONT_MODE_EN
    assign w_cont_in = i_cont;
    assign w_stop    = i_stop;
`else
    assign w_cont_in = 1'b0;
    assign w_stop    = 1'b0;
`endif

    assign w_accept = (r_state == S_IDLE) && i_start && (i_m_in != '0);
    assign w_run    = (r_state == S_RUN);
    // The sample counter holds the number of samples since the last tick, so a
    // tick falls on every M-th sampled bit. M=1 therefore ticks on every cycle.
    assign w_tick   = w_run && (r_cnt == (r_m - M_W'(1)));
    assign w_d_ext  = {{(OUT_W-1){1'b0}}, i_d_in};

    // Integrator and comb cascades are resolved within one cycle. The comb chain
    // consumes the freshly updated last integrator.
    always_comb begin
        w_integ_next[0] = w_integ_q[0] + w_d_ext;
        for (int k = 1; k < ORDER; k++) begin
            w_integ_next[k] = w_integ_q[k] + w_integ_next[k-1];
        end
        w_comb[0] = w_integ_next[ORDER-1];
        for (int k = 0; k < ORDER; k++) begin
            w_comb[k+1] = w_comb[k] - w_dly_q[k];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ORDER; gi++) begin : g_stage
            logic [OUT_W-1:0] r_integ;
            logic [OUT_W-1:0] r_dly;

            assign w_integ_q[gi] = r_integ;
            assign w_dly_q[gi]   = r_dly;

            // Per-stage state: the integrator runs only in RUN, and the comb delay loads on ticks.
            always_ff @(posedge i_clk or negedge i_rstb) begin
                if (!i_rstb) begin
                    r_integ <= '0;
                    r_dly   <= '0;
                end else if (w_accept) begin
                    r_integ <= '0;
                    r_dly   <= '0;
                end else if (w_run) begin
                    r_integ <= w_integ_next[gi];
                    if (w_tick) begin
                        r_dly <= w_comb[gi];
                    end
                end
            end
        end
    endgenerate

    // Control FSM. It also owns the counters and the registered outputs.
    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            r_state    <= S_IDLE;
            r_m        <= '0;
            r_cnt      <= '0;
            r_ticks    <= '0;
            r_cont     <= 1'b0;
            r_pend     <= 1'b0;
            r_comb_out <= '0;
            o_d_out    <= '0;
            o_valid    <= 1'b0;
            o_done     <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_m     <= i_m_in;
                        r_cont  <= w_cont_in;
                        r_cnt   <= '0;
                        r_ticks <= '0;
                        r_pend  <= 1'b0;
                        o_done  <= 1'b0;
                        o_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_cont && w_stop) begin
                        // Stopping drops any result still waiting to be delivered.
                        r_pend  <= 1'b0;
                        o_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        if (r_pend) begin
                            o_d_out <= r_comb_out;
                            o_valid <= 1'b1;
                            r_pend  <= 1'b0;
                        end
                        if (w_tick) begin
                            r_cnt      <= '0;
                            r_comb_out <= w_comb[ORDER];
                            if (r_ticks != TICK_ORDER) begin
                                r_ticks <= r_ticks + 3'd1;
                            end
                            if (r_ticks >= TICK_LAST) begin
                                if (r_cont) begin
                                    r_pend <= 1'b1;
                                end else begin
                                    r_state <= S_OUT;
                                end
                            end
                        end else begin
                            r_cnt <= r_cnt + M_W'(1);
                        end
                    end
                end
                S_OUT: begin
                    o_d_out <= r_comb_out;
                    o_valid <= 1'b1;
                    o_done  <= 1'b1;
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cic_decim_n.sv
// Bench for cic_decim_n. Two instances are used: ORDER=2 and ORDER=3, both
// with M_W=10. The expected values come from a reference model: the impulse
// response (ORDER boxcars of length M, convolved) is applied to the sampled bits.
module tb_cic_decim_n;

    localparam int M_W = 10;
    localparam int W2  = 2*(M_W-1)+1;
    localparam int W3  = 3*(M_W-1)+1;

    logic clk  = 1'b0;
    logic rstb = 1'b0;

    logic           start2 = 1'b0;
    logic           d2     = 1'b0;
    logic [M_W-1:0] m2     = '0;
    logic [W2-1:0]  dout2;
    logic           valid2, done2, busy2;

    logic           start3 = 1'b0;
    logic           d3     = 1'b0;
    logic [M_W-1:0] m3     = '0;
    logic [W3-1:0]  dout3;
    logic           valid3, done3, busy3;

`ifdef CIC_CONT_MODE_EN
    logic cont2 = 1'b0;
    logic stop2 = 1'b0;
    logic cont3 = 1'b0;
    logic stop3 = 1'b0;
`endif

    int     n_chk  = 0;
    int     n_pass = 0;
    bit     stim  [0:4095];
    longint h_arr [0:4095];
    longint t_arr [0:4095];

    always #5 clk = ~clk;

    cic_decim_n #(.ORDER(2), .M_W(M_W)) u_dut2 (
        .i_clk   (clk),
        .i_rstb  (rstb),
        .i_start (start2),
        .i_m_in  (m2),
        .i_d_in  (d2),
`ifdef CIC_CONT_MODE_EN
        .i_cont  (cont2),
        .i_stop  (stop2),
`endif
        .o_d_out (dout2),
        .o_valid (valid2),
        .o_done  (done2),
        .o_busy  (busy2)
    );

    cic_decim_n #(.ORDER(3), .M_W(M_W)) u_dut3 (
        .i_clk   (clk),
        .i_rstb  (rstb),
        .i_start (start3),
        .i_m_in  (m3),
        .i_d_in  (d3),
`ifdef CIC_CONT_MODE_EN
        .i_cont  (cont3),
        .i_stop  (stop3),
`endif
        .o_d_out (dout3),
        .o_valid (valid3),
        .o_done  (done3),
        .o_busy  (busy3)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    // Reference result, taken at the last sample E(order*m):
    // sum over k of h[k] * x(E(n-k)), reduced modulo 2^out_w.
    function automatic longint cic_ref(input int order, input int m, input int out_w);
        int     len;
        int     nl;
        int     n;
        longint acc;
        h_arr[0] = 1;
        len = 1;
        for (int s = 0; s < order; s++) begin
            nl = len + m - 1;
            for (int i = 0; i < nl; i++) t_arr[i] = 0;
            for (int i = 0; i < len; i++)
                for (int j = 0; j < m; j++)
                    t_arr[i+j] += h_arr[i];
            for (int i = 0; i < nl; i++) h_arr[i] = t_arr[i];
            len = nl;
        end
        n = order * m;
        acc = 0;
        for (int k = 0; k < len; k++)
            if (stim[n-1-k]) acc += h_arr[k];
        return acc & ((longint'(1) << out_w) - 1);
    endfunction

    task automatic set_in(input int sel, input logic st, input logic [M_W-1:0] mm, input logic d);
        if (sel == 0) begin
            start2 = st; m2 = mm; d2 = d;
        end else begin
            start3 = st; m3 = mm; d3 = d;
        end
    endtask

    function automatic logic [63:0] g_dout(input int sel);
        return (sel == 0) ? 64'(dout2) : 64'(dout3);
    endfunction
    function automatic logic [63:0] g_valid(input int sel);
        return (sel == 0) ? 64'(valid2) : 64'(valid3);
    endfunction
    function automatic logic [63:0] g_done(input int sel);
        return (sel == 0) ? 64'(done2) : 64'(done3);
    endfunction
    function automatic logic [63:0] g_busy(input int sel);
        return (sel == 0) ? 64'(busy2) : 64'(busy3);
    endfunction

    task automatic fill_const(input bit v);
        for (int i = 0; i < 4096; i++) stim[i] = v;
    endtask
    task automatic fill_rand();
        for (int i = 0; i < 4096; i++) stim[i] = 1'($urandom);
    endtask

    // One single conversion. After E0, M_in is given a random value every cycle.
    // With poke set, a second start is issued while the block is busy.
    task automatic run_conv(input int sel, input int m, input bit poke, input string tag);
        int     order;
        int     n;
        longint exp;
        order = (sel == 0) ? 2 : 3;
        n = order * m;
        exp = cic_ref(order, m, (sel == 0) ? W2 : W3);
        @(negedge clk);
        set_in(sel, 1'b1, M_W'(m), 1'b0);
        @(negedge clk);
        chk({tag, "/busy_e0"}, g_busy(sel), 64'd1);
        chk({tag, "/done_e0"}, g_done(sel), 64'd0);
        for (int i = 1; i <= n; i++) begin
            set_in(sel, poke && (i == 2), M_W'($urandom_range(1, 1023)), stim[i-1]);
            @(negedge clk);
        end
        chk({tag, "/valid_last"}, g_valid(sel), 64'd0);
        chk({tag, "/busy_last"}, g_busy(sel), 64'd1);
        set_in(sel, 1'b0, M_W'($urandom), 1'($urandom));
        @(negedge clk);
        chk({tag, "/dout"}, g_dout(sel), 64'(exp));
        chk({tag, "/valid"}, g_valid(sel), 64'd1);
        chk({tag, "/done"}, g_done(sel), 64'd1);
        chk({tag, "/busy"}, g_busy(sel), 64'd0);
        @(negedge clk);
        chk({tag, "/valid_drop"}, g_valid(sel), 64'd0);
        chk({tag, "/done_hold"}, g_done(sel), 64'd1);
        $display("conv %s: M=%0d order=%0d d_out=%0d expected=%0d", tag, m, order, g_dout(sel), exp);
    endtask

    // A start with M_in=0 in IDLE must change nothing.
    task automatic idle_zero(input int sel, input string tag);
        @(negedge clk);
        set_in(sel, 1'b1, '0, 1'b1);
        @(negedge clk);
        set_in(sel, 1'b0, '0, 1'b0);
        chk({tag, "/busy"}, g_busy(sel), 64'd0);
        chk({tag, "/done"}, g_done(sel), 64'd1);
        chk({tag, "/valid"}, g_valid(sel), 64'd0);
        @(negedge clk);
        chk({tag, "/busy2"}, g_busy(sel), 64'd0);
        $display("idle start M=0 %s checked", tag);
    endtask

    initial begin
        int sel;
        int m;

        // Reset values, checked while reset is held.
        rstb = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst/dout2", 64'(dout2), 64'd0);
        chk("rst/valid2", 64'(valid2), 64'd0);
        chk("rst/done2", 64'(done2), 64'd0);
        chk("rst/busy2", 64'(busy2), 64'd0);
        chk("rst/dout3", 64'(dout3), 64'd0);
        chk("rst/busy3", 64'(busy3), 64'd0);
        $display("reset state checked");
        rstb = 1'b1;
        @(negedge clk);

        // ORDER=2 with all-ones input gives M^2.
        fill_const(1'b1);
        run_conv(0, 4, 1'b0, "o2_m4_ones");
        chk("o2_m4_ones/const16", 64'(dout2), 64'd16);
        idle_zero(0, "o2_idle_m0");
        run_conv(0, 512, 1'b0, "o2_m512_ones");
        chk("o2_m512_ones/const", 64'(dout2), 64'd262144);

        // A start while busy must be ignored.
        fill_rand();
        run_conv(0, 4, 1'b1, "o2_m4_poke");

        // ORDER=3, M=3 impulses. The response taps are 1,3,6,7,6,3,1, ending at E9.
        fill_const(1'b0); stim[2] = 1'b1;
        run_conv(1, 3, 1'b0, "o3_imp_e3");
        fill_const(1'b0); stim[5] = 1'b1;
        run_conv(1, 3, 1'b0, "o3_imp_e6");
        chk("o3_imp_e6/center", 64'(dout3), 64'd7);
        fill_const(1'b0); stim[0] = 1'b1;
        run_conv(1, 3, 1'b0, "o3_imp_e1");
        idle_zero(1, "o3_idle_m0");

        // Reset in the middle of an M=8 conversion, just after E5.
        fill_const(1'b1);
        @(negedge clk);
        set_in(0, 1'b1, 10'd8, 1'b0);
        @(negedge clk);
        for (int i = 1; i <= 5; i++) begin
            set_in(0, 1'b0, 10'd8, 1'b1);
            @(negedge clk);
        end
        rstb = 1'b0;
        #1;
        chk("midrst/dout2", 64'(dout2), 64'd0);
        chk("midrst/valid2", 64'(valid2), 64'd0);
        chk("midrst/done2", 64'(done2), 64'd0);
        chk("midrst/busy2", 64'(busy2), 64'd0);
        chk("midrst/done3", 64'(done3), 64'd0);
        $display("mid-conversion reset checked");
        @(negedge clk);
        rstb = 1'b1;
        fill_rand();
        run_conv(0, 8, 1'b0, "o2_post_rst");

        // Random patterns and decimation factors on both orders.
        for (int r = 0; r < 6; r++) begin
            sel = r % 2;
            m = (sel == 1) ? int'($urandom_range(1, 12)) : int'($urandom_range(1, 40));
            fill_rand();
            run_conv(sel, m, r[0], $sformatf("rand%0d", r));
        end

        // An M value above the full-scale range wraps modulo 2^OUT_W.
        fill_const(1'b1);
        run_conv(0, 1000, 1'b0, "o2_m1000_wrap");
        chk("o2_m1000_wrap/const", 64'(dout2), 64'd475712);

`ifdef CIC_CONT_MODE_EN
        // Continuous mode: results at E9 and E13, then a stop at E14.
        @(negedge clk);
        start2 = 1'b1; m2 = 10'd4; cont2 = 1'b1; d2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0; cont2 = 1'b0;
        for (int e = 1; e <= 18; e++) begin
            stop2 = (e == 14);
            @(negedge clk);
            chk($sformatf("cont/valid_e%0d", e), 64'(valid2), 64'(e == 9 || e == 13));
            if (e == 9 || e == 13) begin
                chk($sformatf("cont/dout_e%0d", e), 64'(dout2), 64'd16);
                chk($sformatf("cont/done_e%0d", e), 64'(done2), 64'd0);
            end
            if (e >= 14) begin
                chk($sformatf("cont/busy_e%0d", e), 64'(busy2), 64'd0);
            end
        end
        stop2 = 1'b0;
        chk("cont/dout_hold", 64'(dout2), 64'd16);
        $display("continuous mode run checked");
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
